// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  // Arbiter ownership state: free, or locked to requester 0 / requester 1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Requester indices: 0 is the core load/store stage, 1 is the loader/debug port.
  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  // Default address and data widths of the data memory.
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// requesters and memory that surround it.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  // requester 0 (core)
  logic          r0_req;
  logic          r0_we;
  logic          r0_lock;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;
  // requester 1 (loader/debug)
  logic          r1_req;
  logic          r1_we;
  logic          r1_lock;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;
  // memory port
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker. When force_en is set only
// force_id may win (used while a requester holds the lock); otherwise a
// tie goes to the requester that did not win last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_id,
  output logic [1:0] gnt,
  output logic       win
);

  // Select at most one requester and report its index.
  always_comb begin
    gnt = 2'b00;
    win = 1'b0;
    if (force_en) begin
      win      = force_id;
      gnt[win] = req[win];
    end else if (req == 2'b11) begin
      win      = ~last;
      gnt[win] = 1'b1;
    end else if (req[0]) begin
      win    = 1'b0;
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      win    = 1'b1;
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory. Grants are
// combinational from req and the ownership state, the granted requester
// drives the memory port in the same cycle, and read data is registered
// and returned with a one-cycle rvalid pulse.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
)(
  input logic           CLK,
  input logic           Reset,
  dmem_arbiter_if.slave bus
);

  arb_state_t    state_q, state_d;
  logic          last_q, last_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d;
  logic [DW-1:0] r1_rdata_q, r1_rdata_d;

  logic [1:0]    req;
  logic [1:0]    pick_gnt;
  logic          pick_win;
  logic [1:0]    gnt;
  logic          force_en;
  logic          force_id;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;

  assign req      = {bus.r1_req, bus.r0_req};
  assign force_en = (state_q != IDLE);
  assign force_id = (state_q == OWN1);

  rr_pick2 u_pick (
    .req      (req),
    .last     (last_q),
    .force_en (force_en),
    .force_id (force_id),
    .gnt      (pick_gnt),
    .win      (pick_win)
  );

  // Reset blocks every grant immediately, so no strobe can fire while it is held.
  assign gnt = pick_gnt & {2{~Reset}};

  // Next ownership state, round-robin history and read-return capture.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rvalid_d   = 2'b00;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    if (|gnt) begin
      last_d = pick_win;
      if (pick_win == REQ_LOADER) begin
        state_d = bus.r1_lock ? OWN1 : IDLE;
      end else begin
        state_d = bus.r0_lock ? OWN0 : IDLE;
      end
    end else if (state_q != IDLE) begin
      // owner dropped its request while holding the lock
      state_d = IDLE;
    end
    if (gnt[REQ_CORE] && !bus.r0_we) begin
      rvalid_d[REQ_CORE] = 1'b1;
      r0_rdata_d         = bus.mem_rdata;
    end
    if (gnt[REQ_LOADER] && !bus.r1_we) begin
      rvalid_d[REQ_LOADER] = 1'b1;
      r1_rdata_d           = bus.mem_rdata;
    end
  end

  // Memory port follows the granted requester; idle drive is all zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (gnt[REQ_CORE]) begin
      mem_addr  = bus.r0_addr;
      mem_wdata = bus.r0_wdata;
      mem_read  = ~bus.r0_we;
      mem_write = bus.r0_we;
    end else if (gnt[REQ_LOADER]) begin
      mem_addr  = bus.r1_addr;
      mem_wdata = bus.r1_wdata;
      mem_read  = ~bus.r1_we;
      mem_write = bus.r1_we;
    end
  end

  // State, last-winner and read-return registers; reset discards any read in flight.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      rvalid_q   <= 2'b00;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rvalid_q   <= rvalid_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
    end
  end

  assign bus.r0_gnt    = gnt[REQ_CORE];
  assign bus.r1_gnt    = gnt[REQ_LOADER];
  assign bus.r0_rvalid = rvalid_q[REQ_CORE];
  assign bus.r1_rvalid = rvalid_q[REQ_LOADER];
  assign bus.r0_rdata  = r0_rdata_q;
  assign bus.r1_rdata  = r1_rdata_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the stimulus process checks grants and
// memory drive each cycle and queues expected read returns; a monitor pops
// and compares them whenever rvalid is due.
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

  dmem_arbiter #(.AW(8), .DW(8)) u_dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // memory model: combinational read, write at the clock edge; preloaded while in reset
  logic [7:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h5A;
      mem[8'h30] <= 8'h11;
      mem[8'h40] <= 8'h22;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // monitor: rvalid must appear exactly when a queued return is due
  always @(negedge CLK) begin
    logic e0, e1;
    e0 = (q0.size() > 0) && (q0[0].due == cyc);
    e1 = (q1.size() > 0) && (q1[0].due == cyc);
    chk("r0_rvalid", {31'd0, bus.r0_rvalid}, {31'd0, e0});
    if (e0) begin
      chk("r0_rdata", {24'd0, bus.r0_rdata}, {24'd0, q0[0].data});
      void'(q0.pop_front());
    end
    chk("r1_rvalid", {31'd0, bus.r1_rvalid}, {31'd0, e1});
    if (e1) begin
      chk("r1_rdata", {24'd0, bus.r1_rdata}, {24'd0, q1[0].data});
      void'(q1.pop_front());
    end
    chk("strobe_excl", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
  end

  task automatic set_in(input logic q0i, w0, l0, input logic [7:0] a0, d0,
                        input logic q1i, w1, l1, input logic [7:0] a1, d1);
    bus.r0_req = q0i; bus.r0_we = w0; bus.r0_lock = l0; bus.r0_addr = a0; bus.r0_wdata = d0;
    bus.r1_req = q1i; bus.r1_we = w1; bus.r1_lock = l1; bus.r1_addr = a1; bus.r1_wdata = d1;
  endtask

  // one cycle: drive inputs, queue the expected read return, check grant and memory drive
  task automatic cyc_drive(input logic q0i, w0, l0, input logic [7:0] a0, d0,
                           input logic q1i, w1, l1, input logic [7:0] a1, d1,
                           input logic eg0, eg1, pv, input logic [7:0] erd, input string nm);
    logic [7:0] ea, ed;
    logic       er, ew;
    @(posedge CLK); #1;
    set_in(q0i, w0, l0, a0, d0, q1i, w1, l1, a1, d1);
    if (pv && eg0 && !w0) q0.push_back('{cyc + 1, erd});
    if (pv && eg1 && !w1) q1.push_back('{cyc + 1, erd});
    ea = 8'h00; ed = 8'h00; er = 1'b0; ew = 1'b0;
    if (eg0) begin ea = a0; ed = d0; er = ~w0; ew = w0; end
    else if (eg1) begin ea = a1; ed = d1; er = ~w1; ew = w1; end
    @(negedge CLK);
    chk({nm, ".gnt0"}, {31'd0, bus.r0_gnt}, {31'd0, eg0});
    chk({nm, ".gnt1"}, {31'd0, bus.r1_gnt}, {31'd0, eg1});
    chk({nm, ".mem_addr"}, {24'd0, bus.mem_addr}, {24'd0, ea});
    chk({nm, ".mem_wdata"}, {24'd0, bus.mem_wdata}, {24'd0, ed});
    chk({nm, ".mem_read"}, {31'd0, bus.mem_read}, {31'd0, er});
    chk({nm, ".mem_write"}, {31'd0, bus.mem_write}, {31'd0, ew});
  endtask

  task automatic idle(input string nm);
    cyc_drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, nm);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    Reset = 1'b1;
    set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    @(negedge CLK);
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    // requests during reset must not be granted
    set_in(1, 0, 0, 8'h10, 8'h00, 1, 1, 0, 8'h40, 8'h77);
    @(negedge CLK);
    chk("rst.gnt0", {31'd0, bus.r0_gnt}, 32'd0);
    chk("rst.gnt1", {31'd0, bus.r1_gnt}, 32'd0);
    chk("rst.rdata0", {24'd0, bus.r0_rdata}, 32'd0);
    chk("rst.rdata1", {24'd0, bus.r1_rdata}, 32'd0);
    chk("rst.mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rst.mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst.mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    chk("rst.mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    // single read by r0
    cyc_drive(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h5A, "single");
    idle("single_ret");
    chk("single.r1_rdata", {24'd0, bus.r1_rdata}, 32'd0);

    // contention from reset: r0, r1, r0, r1
    do_reset();
    cyc_drive(1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h40, 8'h00, 1, 0, 1, 8'h11, "cont0");
    cyc_drive(1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h40, 8'h00, 0, 1, 1, 8'h22, "cont1");
    cyc_drive(1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h40, 8'h00, 1, 0, 1, 8'h11, "cont2");
    cyc_drive(1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h40, 8'h00, 0, 1, 1, 8'h22, "cont3");

    // lock: r0 read leaves last=0, so r1 wins the tie and keeps ownership
    cyc_drive(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h5A, "lock_pre");
    cyc_drive(1, 0, 0, 8'h30, 8'h00, 1, 1, 1, 8'h20, 8'h33, 0, 1, 1, 8'h00, "lock_wr");
    cyc_drive(1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0, 1, 1, 8'h33, "lock_rd");
    cyc_drive(1, 0, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h11, "lock_post");

    // abandoned lock: r0 locks, then drops req; r1 waits one cycle
    cyc_drive(1, 0, 1, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h5A, "aband_lk");
    cyc_drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00, 0, 0, 1, 8'h00, "aband_drop");
    cyc_drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00, 0, 1, 1, 8'h22, "aband_r1");

    // write then read-back, then a back-to-back read
    cyc_drive(1, 1, 0, 8'hFF, 8'hC3, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00, "wr_ff");
    cyc_drive(1, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'hC3, "rd_ff");
    cyc_drive(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h5A, "rd_b2b");
    idle("b2b_ret");
    idle("hold");
    chk("hold.r0_rdata", {24'd0, bus.r0_rdata}, 32'h5A);

    // reset in the cycle after a granted read: the return is discarded
    cyc_drive(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, "rst_rd");
    @(posedge CLK); #1;
    Reset = 1'b1;
    set_in(1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h40, 8'h00);
    @(negedge CLK);
    chk("mid.gnt0", {31'd0, bus.r0_gnt}, 32'd0);
    chk("mid.gnt1", {31'd0, bus.r1_gnt}, 32'd0);
    chk("mid.mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("mid.mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("mid.mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    chk("mid.r0_rdata", {24'd0, bus.r0_rdata}, 32'd0);
    Reset = 1'b0;
    set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    cyc_drive(1, 0, 0, 8'h30, 8'h00, 1, 0, 0, 8'h40, 8'h00, 1, 0, 1, 8'h11, "post_rst");
    cyc_drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00, 0, 1, 1, 8'h22, "post_rst1");
    idle("drain");
    idle("drain2");

    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
